rv32_multicycle_ctrl: RTL and testbench
=======================================

Name: rv32_multicycle_ctrl

Overview:
- Control FSM that sequences a shared-memory, multi-cycle RV32I datapath built from the existing ALU, register file and decoder.
- Each cycle it drives the datapath enables, mux selects, ALU operation and single-port memory request.
- It stalls on the memory handshake and counts retired instructions.
- It sits between the instruction register/decoder fields and the datapath control inputs, and replaces the single-cycle processor's combinational control.

Parameters:
- CNT_W, 32, width of the retired-instruction counter instret.

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  asynchronous active-high reset.
- opcode  input  7  IR[6:0]; stable from the DECODE state to the end of the instruction.
- funct3  input  3  IR[14:12].
- funct7_5  input  1  IR[30].
- mem_ready  input  1  memory completes the current request this cycle.
- branch_taken  input  1  ALU compare result, valid in EXEC.
- state  output  3  current FSM state, for debug and bench use.
- mem_req  output  1  memory request; held until mem_ready.
- mem_we  output  1  write strobe, qualified by mem_req.
- mem_addr_sel  output  1  0 = PC, 1 = ALU result.
- ir_we  output  1  instruction register load.
- pc_we  output  1  PC update.
- pc_sel  output  2  00 = PC+4, 01 = PC+imm, 10 = (rs1+imm)&~1.
- alu_a_sel  output  1  0 = rs1, 1 = PC.
- alu_b_sel  output  1  0 = rs2, 1 = imm.
- alu_ctrl  output  4  ALU operation code.
- reg_we  output  1  register file write.
- wb_sel  output  2  00 = ALU, 01 = memory data, 10 = PC+4, 11 = imm (LUI).
- illegal  output  1  unsupported opcode trapped.
- instret  output  CNT_W  retired-instruction count.

Behaviour:
- Reset state and outputs:
  - On RST high: state = FETCH (0), instret = 0.
  - While RST is high, all outputs except state are forced to 0.
- State encoding: FETCH = 0, DECODE = 1, EXEC = 2, MEM = 3, WB = 4, TRAP = 5. Codes 6 and 7 go to FETCH.
- FETCH:
  - Drives mem_req = 1, mem_addr_sel = 0, mem_we = 0.
  - Stays in FETCH while mem_ready = 0.
  - On mem_ready = 1: ir_we = 1 for that cycle, then go to DECODE.
- DECODE:
  - All enables 0.
  - Supported opcodes: 0110011 R, 0010011 I-ALU, 0000011 LOAD, 0100011 STORE, 1100011 BRANCH, 1101111 JAL, 1100111 JALR, 0110111 LUI, 0010111 AUIPC.
  - Supported opcode goes to EXEC; any other opcode goes to TRAP.
- EXEC:
  - R: a = rs1, b = rs2, alu_ctrl = {funct7_5, funct3}; go to WB.
  - I-ALU: b = imm. alu_ctrl = {funct7_5, funct3} only when funct3 = 101, otherwise {0, funct3}, so ADDI with IR[30] = 1 is still an add. Go to WB.
  - LOAD/STORE: a = rs1, b = imm, alu_ctrl = 0000; go to MEM.
  - BRANCH: a = rs1, b = rs2, alu_ctrl = 1000 (SUB) for BEQ/BNE, 0010 for BLT/BGE, 0011 for BLTU/BGEU. pc_we = 1, pc_sel = branch_taken ? 01 : 00. Instruction retires; go to FETCH.
  - JAL/JALR/LUI: go to WB.
  - AUIPC: a = PC, b = imm, alu_ctrl = 0000; go to WB.
- MEM:
  - mem_req = 1, mem_addr_sel = 1, mem_we = 1 for STORE only.
  - Stays in MEM until mem_ready.
  - STORE on ready: pc_we = 1, pc_sel = 00, retire, go to FETCH.
  - LOAD on ready: go to WB.
- WB:
  - reg_we = 1 and pc_we = 1 for exactly one cycle, then go to FETCH.
  - wb_sel: LOAD 01, JAL/JALR 10, LUI 11, otherwise 00.
  - pc_sel: JAL 01, JALR 10 (ALU configured as rs1+imm), otherwise 00.
  - Instruction retires.
- TRAP:
  - Absorbing state; illegal = 1 and all other enables 0.
  - Exits only through RST.
- instret:
  - Increments by 1 in every cycle where pc_we = 1 outside TRAP.
  - Wraps from all-ones to 0.
- Latency with mem_ready already high: BRANCH 3 cycles; R, I-ALU, STORE, JAL, JALR, LUI, AUIPC 4 cycles; LOAD 5 cycles. Each memory wait cycle adds 1.
- mem_ready high outside FETCH/MEM is ignored.
- RST asserted mid-instruction aborts it immediately; no partial writes follow, because enables are forced low.
- Default values for any output not listed in a state: 0.

Test Plan:
1. Reset, then mem_ready = 1, opcode = 0110011, funct3 = 000, funct7_5 = 1 (SUB) -> states 0,1,2,4; alu_ctrl = 1000 in EXEC; reg_we = pc_we = 1 in WB; instret = 1 after 4 cycles.
2. LOAD with mem_ready low for 2 cycles in MEM -> MEM held 3 cycles with mem_req = 1, mem_addr_sel = 1; wb_sel = 01 in WB; total 7 cycles.
3. BRANCH, funct3 = 000: branch_taken = 1 gives pc_sel = 01; branch_taken = 0 gives pc_sel = 00. Both return to FETCH after 3 cycles with reg_we never asserted.
4. STORE -> mem_we = 1 only in MEM; reg_we stays 0; JALR -> pc_sel = 10, wb_sel = 10 in WB.
5. opcode = 1111111 -> TRAP after DECODE; illegal = 1 for 10+ cycles, instret frozen, mem_req = 0; RST pulse returns state to 0.
6. CNT_W = 4, 16 retired ADDIs (funct3 = 000, funct7_5 = 1) -> alu_ctrl = 0000 each time, instret wraps 15 -> 0; RST asserted in MEM -> all outputs 0 that same cycle.

Source files
------------

// File: rtl/rv32_multicycle_ctrl_if.sv
// Control bundle between the multicycle RV32I controller and its datapath:
// IR fields and memory/branch status in, datapath enables/selects out.
interface rv32_multicycle_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [6:0]       opcode;
  logic [2:0]       funct3;
  logic             funct7_5;
  logic             mem_ready;
  logic             branch_taken;

  logic [2:0]       state;
  logic             mem_req;
  logic             mem_we;
  logic             mem_addr_sel;
  logic             ir_we;
  logic             pc_we;
  logic [1:0]       pc_sel;
  logic             alu_a_sel;
  logic             alu_b_sel;
  logic [3:0]       alu_ctrl;
  logic             reg_we;
  logic [1:0]       wb_sel;
  logic             illegal;
  logic [CNT_W-1:0] instret;

  modport master (
    input  opcode, funct3, funct7_5, mem_ready, branch_taken,
    output state, mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_sel,
           alu_a_sel, alu_b_sel, alu_ctrl, reg_we, wb_sel, illegal, instret
  );

  modport slave (
    output opcode, funct3, funct7_5, mem_ready, branch_taken,
    input  state, mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_sel,
           alu_a_sel, alu_b_sel, alu_ctrl, reg_we, wb_sel, illegal, instret
  );
endinterface

// File: rtl/rv32_multicycle_ctrl.sv
// Multicycle RV32I control FSM: sequences fetch/decode/exec/mem/writeback over a
// shared single-port memory and counts retired instructions.
//
// state  | meaning
// FETCH  | read instruction at PC, load IR on mem_ready
// DECODE | classify opcode, trap on unsupported
// EXEC   | ALU setup; branches resolve and retire here
// MEM    | load/store access at ALU address; stores retire here
// WB     | register write and PC update, retire
// TRAP   | unsupported opcode, held until reset
module rv32_multicycle_ctrl #(
  parameter int CNT_W = 32
) (
  input logic                   clk,
  input logic                   rst,
  rv32_multicycle_ctrl_if.master bus
);
  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd5
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] instret_q;

  logic       mem_req_c, mem_we_c, mem_addr_sel_c, ir_we_c, pc_we_c;
  logic [1:0] pc_sel_c, wb_sel_c;
  logic       alu_a_sel_c, alu_b_sel_c, reg_we_c, illegal_c;
  logic [3:0] alu_ctrl_c;
  logic       supported;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= FETCH;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      if (pc_we_c && state_q != TRAP)
        instret_q <= instret_q + 1'b1;
    end
  end

  always_comb begin
    supported = 1'b0;
    case (bus.opcode)
      OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH,
      OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: supported = 1'b1;
      default:                           supported = 1'b0;
    endcase
  end

  always_comb begin
    state_d        = state_q;
    mem_req_c      = 1'b0;
    mem_we_c       = 1'b0;
    mem_addr_sel_c = 1'b0;
    ir_we_c        = 1'b0;
    pc_we_c        = 1'b0;
    pc_sel_c       = 2'b00;
    alu_a_sel_c    = 1'b0;
    alu_b_sel_c    = 1'b0;
    alu_ctrl_c     = 4'b0000;
    reg_we_c       = 1'b0;
    wb_sel_c       = 2'b00;
    illegal_c      = 1'b0;

    case (state_q)
      FETCH: begin
        mem_req_c = 1'b1;
        if (bus.mem_ready) begin
          ir_we_c = 1'b1;
          state_d = DECODE;
        end
      end
      DECODE: state_d = supported ? EXEC : TRAP;
      EXEC: begin
        case (bus.opcode)
          OP_R: begin
            alu_ctrl_c = {bus.funct7_5, bus.funct3};
            state_d    = WB;
          end
          OP_I: begin
            alu_b_sel_c = 1'b1;
            // IR[30] only selects SRAI vs SRLI; for other I-ops it is immediate bits
            alu_ctrl_c  = (bus.funct3 == 3'b101) ? {bus.funct7_5, bus.funct3}
                                                 : {1'b0, bus.funct3};
            state_d     = WB;
          end
          OP_LOAD, OP_STORE: begin
            alu_b_sel_c = 1'b1;
            state_d     = MEM;
          end
          OP_BRANCH: begin
            case (bus.funct3[2:1])
              2'b10:   alu_ctrl_c = 4'b0010;
              2'b11:   alu_ctrl_c = 4'b0011;
              default: alu_ctrl_c = 4'b1000;
            endcase
            pc_we_c  = 1'b1;
            pc_sel_c = bus.branch_taken ? 2'b01 : 2'b00;
            state_d  = FETCH;
          end
          OP_AUIPC: begin
            alu_a_sel_c = 1'b1;
            alu_b_sel_c = 1'b1;
            state_d     = WB;
          end
          OP_JAL, OP_JALR, OP_LUI: state_d = WB;
          default:                 state_d = TRAP;
        endcase
      end
      MEM: begin
        mem_req_c      = 1'b1;
        mem_addr_sel_c = 1'b1;
        mem_we_c       = (bus.opcode == OP_STORE);
        if (bus.mem_ready) begin
          if (bus.opcode == OP_STORE) begin
            pc_we_c = 1'b1;
            state_d = FETCH;
          end else begin
            state_d = WB;
          end
        end
      end
      WB: begin
        reg_we_c = 1'b1;
        pc_we_c  = 1'b1;
        state_d  = FETCH;
        case (bus.opcode)
          OP_LOAD: wb_sel_c = 2'b01;
          OP_JAL:  begin wb_sel_c = 2'b10; pc_sel_c = 2'b01; end
          OP_JALR: begin
            wb_sel_c    = 2'b10;
            pc_sel_c    = 2'b10;
            alu_b_sel_c = 1'b1;
          end
          OP_LUI:  wb_sel_c = 2'b11;
          default: wb_sel_c = 2'b00;
        endcase
      end
      TRAP:    illegal_c = 1'b1;
      default: state_d = FETCH;
    endcase
  end

  // Gate with rst so an aborted instruction cannot leak a write in the reset cycle
  assign bus.state        = state_q;
  assign bus.mem_req      = mem_req_c & ~rst;
  assign bus.mem_we       = mem_we_c & ~rst;
  assign bus.mem_addr_sel = mem_addr_sel_c & ~rst;
  assign bus.ir_we        = ir_we_c & ~rst;
  assign bus.pc_we        = pc_we_c & ~rst;
  assign bus.pc_sel       = rst ? 2'b00 : pc_sel_c;
  assign bus.alu_a_sel    = alu_a_sel_c & ~rst;
  assign bus.alu_b_sel    = alu_b_sel_c & ~rst;
  assign bus.alu_ctrl     = rst ? 4'b0000 : alu_ctrl_c;
  assign bus.reg_we       = reg_we_c & ~rst;
  assign bus.wb_sel       = rst ? 2'b00 : wb_sel_c;
  assign bus.illegal      = illegal_c & ~rst;
  assign bus.instret      = rst ? '0 : instret_q;
endmodule

// File: tb/tb_rv32_multicycle_ctrl.sv
// Directed bench for rv32_multicycle_ctrl: instruction-level model of expected
// per-cycle control outputs, run on a 32-bit and a 4-bit instret instance.
module tb_rv32_multicycle_ctrl;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef struct packed {
    logic [2:0] state;
    logic       mem_req;
    logic       mem_we;
    logic       mem_addr_sel;
    logic       ir_we;
    logic       pc_we;
    logic [1:0] pc_sel;
    logic       alu_a_sel;
    logic       alu_b_sel;
    logic [3:0] alu_ctrl;
    logic       reg_we;
    logic [1:0] wb_sel;
    logic       illegal;
  } outs_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_5, mem_ready, branch_taken;

  rv32_multicycle_ctrl_if #(.CNT_W(32)) bus32 ();
  rv32_multicycle_ctrl_if #(.CNT_W(4))  bus4 ();

  assign bus32.opcode = opcode;       assign bus4.opcode = opcode;
  assign bus32.funct3 = funct3;       assign bus4.funct3 = funct3;
  assign bus32.funct7_5 = funct7_5;   assign bus4.funct7_5 = funct7_5;
  assign bus32.mem_ready = mem_ready; assign bus4.mem_ready = mem_ready;
  assign bus32.branch_taken = branch_taken;
  assign bus4.branch_taken  = branch_taken;

  rv32_multicycle_ctrl #(.CNT_W(32)) dut32 (.clk(clk), .rst(rst), .bus(bus32));
  rv32_multicycle_ctrl #(.CNT_W(4))  dut4  (.clk(clk), .rst(rst), .bus(bus4));

  always #5 clk = ~clk;

  outs_t act32, act4;
  assign act32 = {bus32.state, bus32.mem_req, bus32.mem_we, bus32.mem_addr_sel, bus32.ir_we,
                  bus32.pc_we, bus32.pc_sel, bus32.alu_a_sel, bus32.alu_b_sel, bus32.alu_ctrl,
                  bus32.reg_we, bus32.wb_sel, bus32.illegal};
  assign act4  = {bus4.state, bus4.mem_req, bus4.mem_we, bus4.mem_addr_sel, bus4.ir_we,
                  bus4.pc_we, bus4.pc_sel, bus4.alu_a_sel, bus4.alu_b_sel, bus4.alu_ctrl,
                  bus4.reg_we, bus4.wb_sel, bus4.illegal};

  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  int unsigned retired = 0;
  string       tag = "reset";
  logic [3:0]  seen_exec_ctrl;
  logic [1:0]  seen_exec_pc_sel, seen_wb_pc_sel, seen_wb_sel;
  logic        seen_reg_we;

  function automatic outs_t idle(input logic [2:0] st);
    outs_t o;
    o = '0;
    o.state = st;
    return o;
  endfunction

  // One clock of stimulus plus the per-cycle comparison against the model
  task automatic step(input logic r, input logic rdy, input logic tk, input outs_t e);
    logic [3:0] ret4;
    rst = r; mem_ready = rdy; branch_taken = tk;
    @(negedge clk);
    if (r) retired = 0;
    ret4 = retired[3:0];
    n_vec++;
    if (act32 !== e) begin
      n_err++;
      $display("FAIL %s outs32 cyc%0d actual=%h required=%h", tag, cyc, act32, e);
    end
    n_vec++;
    if (act4 !== e) begin
      n_err++;
      $display("FAIL %s outs4 cyc%0d actual=%h required=%h", tag, cyc, act4, e);
    end
    n_vec++;
    if (bus32.instret !== retired) begin
      n_err++;
      $display("FAIL %s instret32 cyc%0d actual=%0d required=%0d", tag, cyc, bus32.instret, retired);
    end
    n_vec++;
    if (bus4.instret !== ret4) begin
      n_err++;
      $display("FAIL %s instret4 cyc%0d actual=%0d required=%0d", tag, cyc, bus4.instret, ret4);
    end
    if (act32.state == 3'd2) begin
      seen_exec_ctrl   = act32.alu_ctrl;
      seen_exec_pc_sel = act32.pc_sel;
    end
    if (act32.state == 3'd4) begin
      seen_wb_pc_sel = act32.pc_sel;
      seen_wb_sel    = act32.wb_sel;
    end
    if (act32.reg_we) seen_reg_we = 1'b1;
    if (e.pc_we && !r) retired++;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic lit(input string nm, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  // Expected cycle sequence of one instruction, derived from its class
  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                           input int fw, input int mw, input logic tk, input logic abort_mem);
    outs_t e;
    logic  is_mem;
    opcode = op; funct3 = f3; funct7_5 = f7;
    seen_reg_we = 1'b0;
    e = idle(3'd0); e.mem_req = 1'b1;
    repeat (fw) step(1'b0, 1'b0, 1'b0, e);
    e.ir_we = 1'b1;
    step(1'b0, 1'b1, 1'b0, e);
    step(1'b0, 1'b1, 1'b0, idle(3'd1));
    if (!(op inside {OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC}))
      return;
    e = idle(3'd2);
    is_mem = (op == OP_LOAD || op == OP_STORE);
    if (op == OP_R) e.alu_ctrl = {f7, f3};
    if (op == OP_I) begin
      e.alu_b_sel = 1'b1;
      e.alu_ctrl  = (f3 == 3'b101) ? {f7, f3} : {1'b0, f3};
    end
    if (is_mem) e.alu_b_sel = 1'b1;
    if (op == OP_AUIPC) begin e.alu_a_sel = 1'b1; e.alu_b_sel = 1'b1; end
    if (op == OP_BRANCH) begin
      case (f3)
        3'b100, 3'b101: e.alu_ctrl = 4'b0010;
        3'b110, 3'b111: e.alu_ctrl = 4'b0011;
        default:        e.alu_ctrl = 4'b1000;
      endcase
      e.pc_we  = 1'b1;
      e.pc_sel = tk ? 2'b01 : 2'b00;
    end
    step(1'b0, 1'b1, tk, e);
    if (op == OP_BRANCH) return;
    if (is_mem) begin
      e = idle(3'd3);
      e.mem_req = 1'b1; e.mem_addr_sel = 1'b1; e.mem_we = (op == OP_STORE);
      repeat (mw) step(1'b0, 1'b0, 1'b0, e);
      if (abort_mem) begin
        step(1'b1, 1'b0, 1'b0, idle(3'd0));
        return;
      end
      if (op == OP_STORE) e.pc_we = 1'b1;
      step(1'b0, 1'b1, 1'b0, e);
      if (op == OP_STORE) return;
    end
    e = idle(3'd4);
    e.reg_we = 1'b1; e.pc_we = 1'b1;
    if (op == OP_LOAD) e.wb_sel = 2'b01;
    if (op == OP_JAL || op == OP_JALR) e.wb_sel = 2'b10;
    if (op == OP_LUI) e.wb_sel = 2'b11;
    if (op == OP_JAL) e.pc_sel = 2'b01;
    if (op == OP_JALR) begin e.pc_sel = 2'b10; e.alu_b_sel = 1'b1; end
    step(1'b0, 1'b1, 1'b0, e);
  endtask

  initial begin
    int c0;
    outs_t e;
    rst = 1'b1; opcode = '0; funct3 = '0; funct7_5 = 1'b0;
    mem_ready = 1'b0; branch_taken = 1'b0;
    @(posedge clk); #1;
    step(1'b1, 1'b1, 1'b0, idle(3'd0));
    step(1'b1, 1'b0, 1'b0, idle(3'd0));

    tag = "sub"; c0 = cyc;
    run_instr(OP_R, 3'b000, 1'b1, 0, 0, 1'b0, 1'b0);
    lit("sub_latency", cyc - c0, 4);
    lit("sub_alu_ctrl", int'(seen_exec_ctrl), 8);
    lit("sub_instret", int'(bus32.instret), 1);

    tag = "load_wait"; c0 = cyc;
    run_instr(OP_LOAD, 3'b010, 1'b0, 0, 2, 1'b0, 1'b0);
    lit("load_latency", cyc - c0, 7);
    lit("load_wb_sel", int'(seen_wb_sel), 1);

    tag = "beq_taken"; c0 = cyc;
    run_instr(OP_BRANCH, 3'b000, 1'b0, 0, 0, 1'b1, 1'b0);
    lit("beq_taken_latency", cyc - c0, 3);
    lit("beq_taken_pc_sel", int'(seen_exec_pc_sel), 1);
    lit("beq_taken_reg_we", int'(seen_reg_we), 0);
    tag = "beq_not"; c0 = cyc;
    run_instr(OP_BRANCH, 3'b000, 1'b0, 0, 0, 1'b0, 1'b0);
    lit("beq_not_latency", cyc - c0, 3);
    lit("beq_not_pc_sel", int'(seen_exec_pc_sel), 0);

    tag = "store"; c0 = cyc;
    run_instr(OP_STORE, 3'b010, 1'b0, 1, 0, 1'b0, 1'b0);
    lit("store_latency", cyc - c0, 5);
    lit("store_reg_we", int'(seen_reg_we), 0);
    tag = "jalr";
    run_instr(OP_JALR, 3'b000, 1'b0, 0, 0, 1'b0, 1'b0);
    lit("jalr_pc_sel", int'(seen_wb_pc_sel), 2);
    lit("jalr_wb_sel", int'(seen_wb_sel), 2);
    tag = "jal";   run_instr(OP_JAL,   3'b000, 1'b0, 0, 0, 1'b0, 1'b0);
    tag = "lui";   run_instr(OP_LUI,   3'b000, 1'b0, 0, 0, 1'b0, 1'b0);
    tag = "auipc"; run_instr(OP_AUIPC, 3'b000, 1'b0, 0, 0, 1'b0, 1'b0);
    tag = "srai";  run_instr(OP_I,     3'b101, 1'b1, 0, 0, 1'b0, 1'b0);
    lit("srai_alu_ctrl", int'(seen_exec_ctrl), 13);
    tag = "bltu";  run_instr(OP_BRANCH, 3'b110, 1'b0, 0, 0, 1'b1, 1'b0);
    tag = "blt";   run_instr(OP_BRANCH, 3'b100, 1'b0, 0, 0, 1'b0, 1'b0);
    lit("instret_before_trap", int'(bus32.instret), 12);

    tag = "trap";
    run_instr(7'b1111111, 3'b000, 1'b0, 0, 0, 1'b0, 1'b0);
    e = idle(3'd5); e.illegal = 1'b1;
    repeat (12) step(1'b0, 1'b1, 1'b0, e);
    lit("trap_instret_frozen", int'(bus32.instret), 12);
    step(1'b1, 1'b0, 1'b0, idle(3'd0));
    lit("trap_reset_state", int'(bus32.state), 0);

    tag = "addi_wrap";
    for (int i = 0; i < 16; i++) begin
      run_instr(OP_I, 3'b000, 1'b1, 0, 0, 1'b0, 1'b0);
      if (i == 14) lit("wrap_at_15", int'(bus4.instret), 15);
    end
    lit("addi_alu_ctrl", int'(seen_exec_ctrl), 0);
    lit("wrap_to_0", int'(bus4.instret), 0);
    lit("instret32_16", int'(bus32.instret), 16);

    tag = "abort_mem";
    run_instr(OP_LOAD, 3'b010, 1'b0, 0, 1, 1'b0, 1'b1);
    tag = "after_abort";
    run_instr(OP_R, 3'b111, 1'b0, 0, 0, 1'b0, 1'b0);
    lit("after_abort_instret", int'(bus32.instret), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
